// File: rtl/ime_sad_acc.sv
// Integer-ME SAD accumulator: per-pixel absolute differences, a registered row sum,
// a per-candidate SAD accumulator, and a running minimum over a search.

module ime_abs #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = (a >= b) ? (a - b) : (b - a);
endmodule

module ime_sad_acc #(
  parameter int BIT_DEPTH = 8,
  parameter int ROW_PIX   = 16,
  parameter int ROWS      = 16,
  parameter int CAND_W    = 10,
  parameter int SAD_W     = BIT_DEPTH + 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         row_valid_i,
  input  logic [ROW_PIX*BIT_DEPTH-1:0] cur_row_i,
  input  logic [ROW_PIX*BIT_DEPTH-1:0] ref_row_i,
  input  logic [CAND_W-1:0]            cand_idx_i,
  input  logic                         last_cand_i,
  output logic                         sad_valid_o,
  output logic [SAD_W-1:0]             sad_o,
  output logic [CAND_W-1:0]            sad_idx_o,
  output logic [SAD_W-1:0]             best_sad_o,
  output logic [CAND_W-1:0]            best_idx_o,
  output logic                         done_o
);
  localparam int SUM_W = BIT_DEPTH + 4;
  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  logic [BIT_DEPTH-1:0] diff [ROW_PIX];
  logic [SUM_W-1:0]     row_sum;
  logic [ROW_W-1:0]     row_cnt;
  logic [ROW_W-1:0]     row_now;
  logic [CAND_W-1:0]    idx_hold;

  logic                 s1_valid;
  logic                 s1_first;
  logic                 s1_last;
  logic                 s1_last_cand;
  logic [CAND_W-1:0]    s1_idx;
  logic [SUM_W-1:0]     s1_sum;

  logic [SAD_W-1:0]     acc;
  logic [SAD_W-1:0]     acc_next;

  for (genvar g = 0; g < ROW_PIX; g++) begin : g_abs
    ime_abs #(.W(BIT_DEPTH)) u_abs (
      .a(cur_row_i[g*BIT_DEPTH +: BIT_DEPTH]),
      .b(ref_row_i[g*BIT_DEPTH +: BIT_DEPTH]),
      .y(diff[g])
    );
  end

  always_comb begin
    row_sum = '0;
    for (int i = 0; i < ROW_PIX; i++) begin
      row_sum = row_sum + SUM_W'(diff[i]);
    end
  end

  // A start pulse makes the row arriving in the same cycle row 0 of the new search.
  assign row_now = start_i ? '0 : row_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt      <= '0;
      idx_hold     <= '0;
      s1_valid     <= 1'b0;
      s1_first     <= 1'b0;
      s1_last      <= 1'b0;
      s1_last_cand <= 1'b0;
      s1_idx       <= '0;
      s1_sum       <= '0;
    end else begin
      s1_valid <= row_valid_i;
      if (row_valid_i) begin
        row_cnt      <= (row_now == LAST_ROW) ? '0 : row_now + ROW_W'(1);
        s1_first     <= (row_now == '0);
        s1_last      <= (row_now == LAST_ROW);
        s1_last_cand <= last_cand_i & (row_now == LAST_ROW);
        s1_idx       <= (row_now == '0) ? cand_idx_i : idx_hold;
        s1_sum       <= row_sum;
        if (row_now == '0) begin
          idx_hold <= cand_idx_i;
        end
      end else begin
        row_cnt <= row_now;
      end
    end
  end

  assign acc_next = (s1_first ? '0 : acc) + SAD_W'(s1_sum);

  // Stage-1 data still in flight when start arrives belongs to the old search and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      sad_valid_o <= 1'b0;
      sad_o       <= '0;
      sad_idx_o   <= '0;
      best_sad_o  <= '1;
      best_idx_o  <= '0;
      done_o      <= 1'b0;
    end else begin
      sad_valid_o <= 1'b0;
      done_o      <= 1'b0;
      if (start_i) begin
        best_sad_o <= '1;
        best_idx_o <= '0;
      end else if (s1_valid) begin
        acc <= acc_next;
        if (s1_last) begin
          sad_valid_o <= 1'b1;
          sad_o       <= acc_next;
          sad_idx_o   <= s1_idx;
          done_o      <= s1_last_cand;
          if (acc_next < best_sad_o) begin
            best_sad_o <= acc_next;
            best_idx_o <= s1_idx;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ime_sad_acc.sv
// Directed bench for ime_sad_acc: candidates are generated with a known per-pixel
// difference profile, and expected completions are queued and matched on sad_valid_o.

module tb_ime_sad_acc;
  localparam int BD = 8;
  localparam int RP = 16;
  localparam int CW = 10;
  localparam int SW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_i;
  logic              row_valid_i;
  logic [RP*BD-1:0]  cur_row_i;
  logic [RP*BD-1:0]  ref_row_i;
  logic [CW-1:0]     cand_idx_i;
  logic              last_cand_i;
  logic              sad_valid_o;
  logic [SW-1:0]     sad_o;
  logic [CW-1:0]     sad_idx_o;
  logic [SW-1:0]     best_sad_o;
  logic [CW-1:0]     best_idx_o;
  logic              done_o;

  ime_sad_acc dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start_i),
    .row_valid_i(row_valid_i),
    .cur_row_i(cur_row_i),
    .ref_row_i(ref_row_i),
    .cand_idx_i(cand_idx_i),
    .last_cand_i(last_cand_i),
    .sad_valid_o(sad_valid_o),
    .sad_o(sad_o),
    .sad_idx_o(sad_idx_o),
    .best_sad_o(best_sad_o),
    .best_idx_o(best_idx_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int sad;
    int idx;
    int best_sad;
    int best_idx;
    int done;
    int cycle;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails = 0;
  int model_best = 65535;
  int model_best_idx = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit vld, input logic [RP*BD-1:0] c,
                               input logic [RP*BD-1:0] r, input int idx, input bit last);
    start_i     = st;
    row_valid_i = vld;
    cur_row_i   = c;
    ref_row_i   = r;
    cand_idx_i  = CW'(idx);
    last_cand_i = last;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, '0, '0, 0, 1'b0);
  endtask

  // total is spread over the 256 pixels; sign_mode 0 random, 1 cur>=ref, 2 cur<=ref.
  task automatic sendCandidate(input int idx, input bit last, input int total, input int sign_mode,
                               input int max_gap, input int nrows, input bit start_first,
                               input bit expect_out);
    int sad = 0;
    for (int r = 0; r < nrows; r++) begin
      logic [RP*BD-1:0] cur_v;
      logic [RP*BD-1:0] ref_v;
      int drv_idx;
      bit drv_last;
      for (int p = 0; p < RP; p++) begin
        int gp;
        int d;
        int s;
        logic [7:0] c;
        logic [7:0] rr;
        gp = r * RP + p;
        d = total / 256 + ((gp < total % 256) ? 1 : 0);
        s = (sign_mode == 0) ? int'($urandom_range(0, 1)) : ((sign_mode == 1) ? 1 : 0);
        if (s == 1) begin
          c  = 8'($urandom_range(d, 255));
          rr = 8'(int'(c) - d);
        end else begin
          c  = 8'($urandom_range(0, 255 - d));
          rr = 8'(int'(c) + d);
        end
        cur_v[p*BD +: BD] = c;
        ref_v[p*BD +: BD] = rr;
        sad += (c > rr) ? int'(c - rr) : int'(rr - c);
      end
      drv_idx  = (r == 0) ? idx : int'($urandom_range(0, 1023));
      drv_last = (r == 15) ? last : 1'($urandom_range(0, 1));
      if (start_first && r == 0) begin
        model_best     = 65535;
        model_best_idx = 0;
      end
      if (r == 15 && expect_out) begin
        exp_t e;
        if (sad < model_best) begin
          model_best     = sad;
          model_best_idx = idx;
        end
        e.sad      = sad;
        e.idx      = idx;
        e.best_sad = model_best;
        e.best_idx = model_best_idx;
        e.done     = last ? 1 : 0;
        e.cycle    = cyc + 2;
        sb.push_back(e);
      end
      applyStimulus(start_first && r == 0, 1'b1, cur_v, ref_v, drv_idx, drv_last);
      if (max_gap > 0 && r < nrows - 1) idle(int'($urandom_range(1, max_gap)));
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_sad_valid", int'(sad_valid_o), 0);
    checkOutput("rst_sad", int'(sad_o), 0);
    checkOutput("rst_sad_idx", int'(sad_idx_o), 0);
    checkOutput("rst_best_sad", int'(best_sad_o), 65535);
    checkOutput("rst_best_idx", int'(best_idx_o), 0);
    checkOutput("rst_done", int'(done_o), 0);
  endtask

  // Every sad_valid_o pulse must match the oldest queued completion, including its cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sad_valid_o === 1'b1) begin
      checkOutput("pulse_expected", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sad", int'(sad_o), e.sad);
        checkOutput("sad_idx", int'(sad_idx_o), e.idx);
        checkOutput("best_sad", int'(best_sad_o), e.best_sad);
        checkOutput("best_idx", int'(best_idx_o), e.best_idx);
        checkOutput("done", int'(done_o), e.done);
        checkOutput("latency_cycle", cyc, e.cycle);
      end
    end else if (rst_n === 1'b1 && done_o === 1'b1) begin
      checkOutput("stray_done", int'(done_o), 0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    start_i = 1'b0;
    row_valid_i = 1'b0;
    cur_row_i = '0;
    ref_row_i = '0;
    cand_idx_i = '0;
    last_cand_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetState();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    $display("[TB] identical rows, idx 5");
    sendCandidate(5, 1'b1, 0, 0, 0, 16, 1'b1, 1'b1);
    idle(4);

    $display("[TB] full-scale difference both directions");
    sendCandidate(7, 1'b1, 65280, 1, 0, 16, 1'b1, 1'b1);
    idle(3);
    sendCandidate(8, 1'b1, 65280, 2, 0, 16, 1'b1, 1'b1);
    idle(4);

    $display("[TB] three back-to-back candidates with a tie");
    sendCandidate(1, 1'b0, 300, 0, 0, 16, 1'b1, 1'b1);
    sendCandidate(2, 1'b0, 120, 0, 0, 16, 1'b0, 1'b1);
    sendCandidate(3, 1'b1, 120, 0, 0, 16, 1'b0, 1'b1);
    idle(4);

    $display("[TB] identical rows with idle gaps");
    sendCandidate(5, 1'b1, 0, 0, 3, 16, 1'b1, 1'b1);
    idle(4);

    $display("[TB] abort after 7 rows, then diff-1 candidate");
    sendCandidate(4, 1'b0, 500, 0, 0, 7, 1'b1, 1'b0);
    sendCandidate(9, 1'b1, 256, 0, 0, 16, 1'b1, 1'b1);
    idle(4);

    $display("[TB] start coinciding with a completion");
    sendCandidate(11, 1'b1, 50, 0, 0, 16, 1'b1, 1'b0);
    sendCandidate(12, 1'b1, 700, 0, 0, 16, 1'b1, 1'b1);
    idle(4);

    $display("[TB] reset mid-candidate");
    sendCandidate(3, 1'b1, 1000, 0, 0, 5, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetState();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_best = 65535;
    model_best_idx = 0;
    sendCandidate(6, 1'b1, 512, 0, 0, 16, 1'b0, 1'b1);
    idle(6);

    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/ime_sad_acc.md
Name: ime_sad_acc

Overview:
- Consumer end of the integer-ME absolute-difference datapath.
- Accepts one 16-pixel row pair (current MB row, reference candidate row) per cycle and forms per-pixel absolute differences, using ime_abs instances, one per pixel lane.
- Reduces each row through a registered adder tree and accumulates 16 rows into a per-candidate SAD.
- Tracks the minimum SAD and its candidate index across a search; the result goes to the IME decision logic.

Parameters:
- BIT_DEPTH, 8, pixel width (matches `BIT_DEPTH).
- ROW_PIX, 16, pixels per row lane; fixed at 16.
- ROWS, 16, rows per candidate; fixed at 16.
- CAND_W, 10, width of candidate index.
- SAD_W, BIT_DEPTH+8, SAD width; worst case 255*256=65280 fits 16 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; begins a new search
- row_valid_i  in  1  row pair valid this cycle
- cur_row_i  in  ROW_PIX*BIT_DEPTH  current MB row; pixel 0 in LSBs
- ref_row_i  in  ROW_PIX*BIT_DEPTH  reference row; same packing
- cand_idx_i  in  CAND_W  candidate index; sampled on row 0 of each candidate
- last_cand_i  in  1  final candidate of search; sampled on row 15
- sad_valid_o  out  1  one-cycle pulse; sad_o/sad_idx_o valid
- sad_o  out  SAD_W  SAD of completed candidate
- sad_idx_o  out  CAND_W  index of completed candidate
- best_sad_o  out  SAD_W  running minimum SAD
- best_idx_o  out  CAND_W  index of running minimum
- done_o  out  1  one-cycle pulse; search complete, best_* final

Behaviour:
- Reset, asynchronous on rst_n low: all outputs and internal registers 0, except best_sad_o = all ones. Row counter 0, pipeline empty.
- No backpressure. Gaps (row_valid_i low) are allowed anywhere; only valid cycles advance the row counter and pipeline.
- Row counter 0..15:
  - increments on each row_valid_i;
  - wraps 15->0;
  - row 0 captures cand_idx_i;
  - row 15 captures last_cand_i.
- Stage 1, edge after the input cycle: 16 abs diffs are summed into a BIT_DEPTH+4 bit row sum and registered with valid, first and last flags, idx and last_cand.
- Stage 2, next valid stage-1 edge: acc = (first ? 0 : acc) + row_sum, at SAD_W bits, no saturation needed.
  - When the stage-1 last flag is set, the same edge also loads sad_o, sad_idx_o and sad_valid_o = 1.
  - If the final sum < best_sad_o (strict), the same edge loads best_sad_o and best_idx_o. Ties keep the earlier candidate.
  - If last_cand is set, done_o = 1 on the same edge.
- Latency: row 15 presented in cycle t -> sad_valid_o, updated best_* and done_o high in cycle t+2.
- sad_valid_o and done_o are single-cycle pulses. sad_o, sad_idx_o and best_* hold until overwritten.
- start_i:
  - clears row counter to 0, best_sad_o to all ones, best_idx_o to 0;
  - flushes stage-1/stage-2 valids, so in-flight partial or complete candidates are discarded and produce no sad_valid_o or done_o;
  - with row_valid_i in the same cycle, that row is row 0 of the new search.
- start_i in the same cycle as an internal completion: start wins; no pulse is issued.
- After done_o, best_* hold until the next start_i or reset.
- Reset asserted mid-candidate: immediate return to reset state; nothing from the old search is emitted after release.

Test Plan:
- Single candidate, cur == ref for all 16 rows, idx 5, last_cand on row 15 -> sad_o=0, sad_idx_o=5, best 0/5, sad_valid_o and done_o pulse 2 cycles after row 15.
- cur all 255, ref all 0, one candidate -> sad_o=65280 (0xFF00). Repeat with cur 0 / ref 255 -> 65280 (symmetry check on abs).
- Three back-to-back candidates with SADs 300 (idx 1), 120 (idx 2), 120 (idx 3) -> three sad_valid_o pulses, 16 cycles apart. best_sad_o=120, best_idx_o=2 (tie keeps earlier). done_o only with the third.
- Same candidate as the cur == ref case, but with random row_valid_i gaps (e.g. 1-3 idle cycles between rows) -> same SAD as gap-free. sad_valid_o 2 valid-pipeline steps after row 15, single pulse.
- start_i pulsed after 7 rows of a candidate, then a full new candidate (each pixel diff 1, idx 9) -> no output for the aborted candidate. sad_o=256, best 256/9.
- rst_n low for one cycle mid-candidate, then a full candidate with pixel diff 2 -> all outputs 0 and best_sad_o=0xFFFF during reset. Next result sad_o=512 with no stale pulse.
